// File: rtl/prbs_checker.sv
// Receive-side PRBS BERT checker: self-seeds an LFSR from incoming words, locks after a run of
// correctly predicted words, then accumulates bit errors until the error density forces a reseed.
//
// state  | meaning
// IDLE   | checker disabled, waiting for en
// SEED   | LFSR loaded directly from received words
// SYNC   | LFSR free-running, counting consecutive clean predictions
// LOCKED | LFSR free-running, accumulating error and compared-bit counts
module prbs_checker #(
   parameter int Length     = 31,
   parameter int OutBits    = 16,
   parameter int LockCount  = 8,
   parameter int WindowLen  = 256,
   parameter int ErrThresh  = 16,
   parameter int CountWidth = 48
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [OutBits-1:0]    in_data,
   input  logic                  in_inv,
   output logic                  locked,
   output logic                  lol_sticky,
   output logic                  err_word,
   output logic [OutBits-1:0]    err_bits,
   output logic [CountWidth-1:0] err_count,
   output logic [CountWidth-1:0] bit_count,
   output logic [1:0]            fsm_state
);

   localparam int SeedWords = (Length + OutBits - 1) / OutBits;
   // Second feedback tap of the standard PRBS polynomials x^Length + x^TapB + 1
   localparam int TapB = (Length == 7)  ? 6  : (Length == 9)  ? 5  : (Length == 11) ? 9 :
                         (Length == 15) ? 14 : (Length == 23) ? 18 : 28;
   localparam int SW = $clog2(SeedWords + 1);
   localparam int GW = $clog2(LockCount + 1);
   localparam int WW = $clog2(WindowLen + 1);
   localparam int BW = $clog2(ErrThresh + 1);

   localparam logic [SW-1:0]       SEED_LAST   = SW'(SeedWords - 1);
   localparam logic [GW-1:0]       LOCK_LAST   = GW'(LockCount - 1);
   localparam logic [WW-1:0]       WIN_LAST    = WW'(WindowLen - 1);
   localparam logic [BW-1:0]       THRESH_LAST = BW'(ErrThresh - 1);
   localparam logic [CountWidth:0] BIT_INC     = (CountWidth + 1)'(OutBits);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEED   = 2'd1,
      SYNC   = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [Length-1:0]       st_q, st_d;
   logic [SW-1:0]           seed_q, seed_d;
   logic [GW-1:0]           good_q, good_d;
   logic [WW-1:0]           win_q, win_d;
   logic [BW-1:0]           bad_q, bad_d;
   logic                    lol_q, lol_d;
   logic                    err_word_q, err_word_d;
   logic [OutBits-1:0]      err_bits_q, err_bits_d;
   logic [CountWidth-1:0]   err_cnt_q, err_cnt_d;
   logic [CountWidth-1:0]   bit_cnt_q, bit_cnt_d;

   logic [OutBits-1:0]      d_word, exp_word, mask;
   logic [Length-1:0]       shifted, nx;
   logic [CountWidth:0]     bit_sum;
   logic                    cmp, inc;

   // OutBits single-bit LFSR steps; st[0] is the oldest bit, new bits enter at the top
   function automatic logic [Length-1:0] prbs_advance(input logic [Length-1:0] s);
      logic [Length-1:0] v;
      v = s;
      for (int i = 0; i < OutBits; i++) v = {v[0] ^ v[Length-TapB], v[Length-1:1]};
      return v;
   endfunction

   function automatic logic [CountWidth-1:0] popcount(input logic [OutBits-1:0] m);
      logic [CountWidth-1:0] c;
      c = '0;
      for (int i = 0; i < OutBits; i++) c = c + CountWidth'(m[i]);
      return c;
   endfunction

   always_comb begin
      d_word   = in_data ^ {OutBits{in_inv}};
      shifted  = {d_word, st_q[Length-1:OutBits]};
      nx       = prbs_advance(st_q);
      exp_word = nx[Length-1:Length-OutBits];
      mask     = d_word ^ exp_word;
      bit_sum  = {1'b0, bit_cnt_q} + BIT_INC;
   end

   always_comb begin
      state_d    = state_q;
      st_d       = st_q;
      seed_d     = seed_q;
      good_d     = good_q;
      win_d      = win_q;
      bad_d      = bad_q;
      lol_d      = lol_q;
      err_word_d = err_word_q;
      err_bits_d = err_bits_q;
      err_cnt_d  = err_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      cmp        = 1'b0;
      inc        = 1'b0;

      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SEED;
               seed_d  = '0;
            end
            SEED: if (in_valid) begin
               st_d = shifted;
               if (seed_q == SEED_LAST) begin
                  seed_d = '0;
                  if (|shifted) begin
                     state_d = SYNC;
                     good_d  = '0;
                  end
               end else begin
                  seed_d = seed_q + 1'b1;
               end
            end
            SYNC: if (in_valid) begin
               cmp = 1'b1;
               if (mask == '0) begin
                  st_d = nx;
                  if (good_q == LOCK_LAST) begin
                     state_d = LOCKED;
                     win_d   = '0;
                     bad_d   = '0;
                  end else begin
                     good_d = good_q + 1'b1;
                  end
               end else begin
                  st_d    = shifted;
                  state_d = SEED;
                  seed_d  = SW'(1);
               end
            end
            default: if (in_valid) begin
               cmp  = 1'b1;
               inc  = 1'b1;
               st_d = nx;
               // Threshold check precedes window rollover so a final-word hit still drops lock
               if ((|mask) && (bad_q == THRESH_LAST)) begin
                  state_d = SEED;
                  seed_d  = '0;
                  lol_d   = 1'b1;
                  win_d   = '0;
                  bad_d   = '0;
               end else if (win_q == WIN_LAST) begin
                  win_d = '0;
                  bad_d = '0;
               end else begin
                  win_d = win_q + 1'b1;
                  if (|mask) bad_d = bad_q + 1'b1;
               end
            end
         endcase
      end

      if (cmp) begin
         err_word_d = |mask;
         err_bits_d = mask;
      end

      // Both counters freeze together so the error ratio stays meaningful at saturation
      if (clear) begin
         err_cnt_d = '0;
         bit_cnt_d = '0;
         lol_d     = 1'b0;
      end else if (inc && !bit_sum[CountWidth]) begin
         err_cnt_d = err_cnt_q + popcount(mask);
         bit_cnt_d = bit_sum[CountWidth-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         st_q       <= '0;
         seed_q     <= '0;
         good_q     <= '0;
         win_q      <= '0;
         bad_q      <= '0;
         lol_q      <= 1'b0;
         err_word_q <= 1'b0;
         err_bits_q <= '0;
         err_cnt_q  <= '0;
         bit_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         st_q       <= st_d;
         seed_q     <= seed_d;
         good_q     <= good_d;
         win_q      <= win_d;
         bad_q      <= bad_d;
         lol_q      <= lol_d;
         err_word_q <= err_word_d;
         err_bits_q <= err_bits_d;
         err_cnt_q  <= err_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign locked     = (state_q == LOCKED);
   assign fsm_state  = state_q;
   assign lol_sticky = lol_q;
   assign err_word   = err_word_q;
   assign err_bits   = err_bits_q;
   assign err_count  = err_cnt_q;
   assign bit_count  = bit_cnt_q;

endmodule
